// File: rtl/adder_share_arb.sv
// adder_share_arb: NREQ requesters share one registered adder.
// The requester that wins arbitration gets A+B computed with IGNORE_BIT truncated LSBs
// (A forced to 1, B forced to 0) and registered with its index.
// Define ADDER_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority.
module adder_share_arb #(
  parameter int WIDTH      = 16,
  parameter int IGNORE_BIT = 0,
  parameter int NREQ       = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ_VALID,
  output logic [NREQ-1:0]          REQ_READY,
  input  logic [NREQ*WIDTH-1:0]    REQ_A,
  input  logic [NREQ*WIDTH-1:0]    REQ_B,
  output logic                     RES_VALID,
  input  logic                     RES_READY,
  output logic [WIDTH-1:0]         RES_DATA,
  output logic [$clog2(NREQ)-1:0]  RES_ID
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] LSB_MASK = (WIDTH'(1) << IGNORE_BIT) - WIDTH'(1);

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [IDW-1:0]   res_id;
  logic             accept;
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand_idx;
  logic [NREQ-1:0]  ready_vec;
  logic [WIDTH-1:0] a_mod;
  logic [WIDTH-1:0] b_mod;
  logic [WIDTH-1:0] sum;
  logic             req_xfer;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = REQ_A[g*WIDTH +: WIDTH];
    assign b_arr[g] = REQ_B[g*WIDTH +: WIDTH];
  end

  // A new operand can be taken when the result slot is empty or being drained
  assign accept = (~res_valid | RES_READY) & ~RST;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr;

  // Priority search starting at the pointer, wrapping modulo NREQ
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_idx = IDW'((32'(ptr) + i) % NREQ);
      if (!grant_any && REQ_VALID[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Pointer moves past the winner only on an actual transfer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (req_xfer) begin
      ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  // Fixed priority: lowest asserted index wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_idx = IDW'(i);
      if (!grant_any && REQ_VALID[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end
`endif

  // One-hot grant to the winner when the result slot can accept
  always_comb begin
    ready_vec = '0;
    if (grant_any && accept) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign req_xfer = grant_any & accept;

  // Truncated signed add: ignored LSBs of A set, of B cleared, wrap modulo 2^WIDTH
  always_comb begin
    a_mod = a_arr[grant_idx] | LSB_MASK;
    b_mod = b_arr[grant_idx] & ~LSB_MASK;
    sum   = a_mod + b_mod;
  end

  // Result register: load on request transfer, clear valid when drained with no reload
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (req_xfer) begin
      res_valid <= 1'b1;
      res_data  <= sum;
      res_id    <= grant_idx;
    end else if (RES_READY) begin
      res_valid <= 1'b0;
    end
  end

  assign REQ_READY = ready_vec;
  assign RES_VALID = res_valid;
  assign RES_DATA  = res_data;
  assign RES_ID    = res_id;

endmodule
